pwm_duty_feeder: RTL and testbench

// - Upstream stage of the PWM output stage. Buffers signed audio samples arriving on a

---
 rtl/pwm_duty_feeder_pkg.sv | 14 +
 rtl/pwm_duty_feeder_fifo.sv | 58 +++++
 rtl/pwm_duty_feeder.sv | 144 ++++++++++++++
 tb/tb_pwm_duty_feeder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_duty_feeder_pkg.sv
// Shared state type, duty width and mid-scale helper for the PWM duty feeder.
package pwm_pkg;

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} feeder_state_t;

    localparam int DUTY_W = 4;

    typedef logic [DUTY_W-1:0] duty_t;

    function automatic int duty_mid(input int n);
        return 1 << (n - 1);
    endfunction

endpackage

// File: rtl/pwm_duty_feeder_fifo.sv
// sample_fifo: small circular sample buffer with occupancy count and synchronous flush.
module sample_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             wr_data,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/pwm_duty_feeder.sv
// Buffers signed samples, applies volume and emits one duty word per PWM period.
// Optional dither is enabled by defining PWM_DUTY_FEEDER_DITHER_EN.
module pwm_duty_feeder
    import pwm_pkg::*;
#(
    parameter int N        = DUTY_W,
    parameter int SAMPLE_W = 8,
    parameter int DEPTH    = 4,
    parameter int PRIME    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [SAMPLE_W-1:0]    s_data,
    input  logic                   period_tick,
    input  logic                   vol_up,
    input  logic                   vol_dn,
    output logic [N-1:0]           duty,
    output logic                   underrun,
    output logic [$clog2(DEPTH):0] level
);

    localparam int            LW        = $clog2(DEPTH) + 1;
    localparam logic [N-1:0]  MID       = N'(duty_mid(N));
    localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME);

    feeder_state_t               state;
    logic [1:0]                  vol;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [SAMPLE_W-1:0]         fifo_head;
    logic                        do_push;
    logic                        do_pop;
    logic                        do_flush;
    logic signed [SAMPLE_W-1:0]  head_s;
    logic signed [SAMPLE_W-1:0]  scaled;
    logic [SAMPLE_W-1:0]         offset_u;
    logic [SAMPLE_W-1:0]         dithered;
    logic [N-1:0]                duty_next;

    assign s_ready  = !fifo_full;
    assign do_push  = s_valid && s_ready;
    assign do_pop   = (state == S_RUN) && ena && period_tick && !fifo_empty;
    assign do_flush = (state == S_RUN) && !ena;

    sample_fifo #(
        .W     (SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (do_push),
        .pop     (do_pop),
        .flush   (do_flush),
        .wr_data (s_data),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // Offset binary is the signed value with its sign bit inverted.
    assign head_s   = fifo_head;
    assign scaled   = head_s >>> (2'd3 - vol);
    assign offset_u = {~scaled[SAMPLE_W-1], scaled[SAMPLE_W-2:0]};

`ifdef PWM_DUTY_FEEDER_DITHER_EN
    localparam int DW = SAMPLE_W - N;

    logic [7:0]        lfsr;
    logic [SAMPLE_W:0] dith_sum;

    assign dith_sum = {1'b0, offset_u} + {{(SAMPLE_W + 1 - DW){1'b0}}, lfsr[DW-1:0]};
    assign dithered = dith_sum[SAMPLE_W] ? '1 : dith_sum[SAMPLE_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 8'hA5;
        end else if (do_pop) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end
`else
    assign dithered = offset_u;
`endif

    assign duty_next = N'(dithered >> (SAMPLE_W - N));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vol <= 2'd2;
        end else if (vol_up && !vol_dn && vol != 2'd3) begin
            vol <= vol + 2'd1;
        end else if (vol_dn && !vol_up && vol != 2'd0) begin
            vol <= vol - 2'd1;
        end
    end

    // Dropping ena always wins over a tick arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            duty     <= MID;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            case (state)
                S_IDLE: begin
                    duty <= MID;
                    if (ena) state <= S_PRIME;
                end
                S_PRIME: begin
                    if (!ena) begin
                        state <= S_IDLE;
                        duty  <= MID;
                    end else if (level >= PRIME_LVL) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!ena) begin
                        state <= S_IDLE;
                        duty  <= MID;
                    end else if (period_tick) begin
                        if (!fifo_empty) begin
                            duty <= duty_next;
                        end else begin
                            underrun <= 1'b1;
                            duty     <= MID;
                            state    <= S_PRIME;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    duty  <= MID;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_duty_feeder.sv
// Self-checking bench for pwm_duty_feeder: directed table, random run against a queue model, dither pop run.
module tb_pwm_duty_feeder;

    localparam int N     = 4;
    localparam int SW    = 8;
    localparam int DEPTH = 4;
    localparam int PRIME = 2;
    localparam int MID   = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic          s_valid;
    logic          s_ready;
    logic [SW-1:0] s_data;
    logic          period_tick;
    logic          vol_up;
    logic          vol_dn;
    logic [N-1:0]  duty;
    logic          underrun;
    logic [$clog2(DEPTH):0] level;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: mode 0 idle, 1 priming, 2 running; queue holds signed samples.
    int mq[$];
    int m_mode;
    int m_vol;
    int m_duty;
    int m_under;
    int m_lfsr;
    int m_pops;
    bit m_popped;

    typedef struct {
        bit       ena;
        bit       valid;
        bit [7:0] data;
        bit       tick;
        bit       up;
        bit       dn;
        int       duty;
        int       level;
        int       under;
        int       ready;
    } vec_t;

    vec_t vecs[29];

    always #5 clk = ~clk;

    pwm_duty_feeder #(
        .N        (N),
        .SAMPLE_W (SW),
        .DEPTH    (DEPTH),
        .PRIME    (PRIME)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .period_tick (period_tick),
        .vol_up      (vol_up),
        .vol_dn      (vol_dn),
        .duty        (duty),
        .underrun    (underrun),
        .level       (level)
    );

    function automatic int convert(input int x, input int vol, input int dith);
        int sc;
        int u;
        sc = x >>> (3 - vol);
        u  = (sc + (1 << (SW - 1))) & ((1 << SW) - 1);
        u  = u + dith;
        if (u > (1 << SW) - 1) u = (1 << SW) - 1;
        return u / (1 << (SW - N));
    endfunction

    task automatic model_reset();
        mq.delete();
        m_mode   = 0;
        m_vol    = 2;
        m_duty   = MID;
        m_under  = 0;
        m_lfsr   = 8'hA5;
        m_pops   = 0;
        m_popped = 1'b0;
    endtask

    task automatic model_step(input bit e, input bit v, input int d, input bit t, input bit u, input bit dn);
        int  nmode;
        int  nduty;
        int  dith;
        bit  push;
        bit  pop;
        bit  flush;
        push  = v && (mq.size() < DEPTH);
        pop   = 1'b0;
        flush = 1'b0;
        nmode = m_mode;
        nduty = m_duty;
        m_under = 0;
`ifdef PWM_DUTY_FEEDER_DITHER_EN
        dith = m_lfsr % (1 << (SW - N));
`else
        dith = 0;
`endif
        case (m_mode)
            0: begin
                nduty = MID;
                if (e) nmode = 1;
            end
            1: begin
                if (!e) begin
                    nmode = 0;
                    nduty = MID;
                end else if (mq.size() >= PRIME) begin
                    nmode = 2;
                end
            end
            default: begin
                if (!e) begin
                    nmode = 0;
                    nduty = MID;
                    flush = 1'b1;
                end else if (t) begin
                    if (mq.size() > 0) begin
                        pop   = 1'b1;
                        nduty = convert(mq[0], m_vol, dith);
                    end else begin
                        m_under = 1;
                        nduty   = MID;
                        nmode   = 1;
                    end
                end
            end
        endcase
        if (pop) begin
            m_lfsr = ((m_lfsr * 2) + (((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1)) % 256;
            void'(mq.pop_front());
            m_pops++;
        end
        if (push) mq.push_back(d);
        if (flush) mq.delete();
        if (u && !dn && m_vol < 3) m_vol++;
        else if (dn && !u && m_vol > 0) m_vol--;
        m_mode   = nmode;
        m_duty   = nduty;
        m_popped = pop;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        n_compared++;
        if (act != exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs, advances the model, and returns at the following negedge.
    task automatic applyStimulus(input bit e, input bit v, input bit [7:0] d, input bit t, input bit u, input bit dn);
        ena         = e;
        s_valid     = v;
        s_data      = d;
        period_tick = t;
        vol_up      = u;
        vol_dn      = dn;
        model_step(e, v, int'($signed(d)), t, u, dn);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkAgainstModel(input string tag);
        checkOutput({tag, "_duty"},     int'(duty),     m_duty);
        checkOutput({tag, "_level"},    int'(level),    mq.size());
        checkOutput({tag, "_underrun"}, int'(underrun), m_under);
        checkOutput({tag, "_ready"},    int'(s_ready),  (mq.size() < DEPTH) ? 1 : 0);
    endtask

    task automatic resetDut();
        ena = 1'b0; s_valid = 1'b0; s_data = '0; period_tick = 1'b0; vol_up = 1'b0; vol_dn = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int exp_duty;
        int n8_dut;
        int n9_dut;
        int n8_ref;
        int n9_ref;
        int cyc;

        vecs[0]  = '{1'b0, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0,  8, 1, 0, 1};
        vecs[1]  = '{1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0,  8, 2, 0, 1};
        vecs[2]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0,  8, 3, 0, 1};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0,  8, 3, 0, 1};
        vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,  8, 3, 0, 1};
        vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,  8, 3, 0, 1};
        vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 15, 2, 0, 1};
        vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 15, 2, 0, 1};
        vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0,  0, 1, 0, 1};
        vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0,  8, 0, 0, 1};
        vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0,  8, 0, 1, 1};
        vecs[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,  8, 0, 0, 1};
        vecs[12] = '{1'b1, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b1,  8, 1, 0, 1};
        vecs[13] = '{1'b1, 1'b1, 8'h80, 1'b0, 1'b1, 1'b1,  8, 2, 0, 1};
        vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,  8, 2, 0, 1};
        vecs[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 11, 1, 0, 1};
        vecs[16] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 11, 1, 0, 1};
        vecs[17] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 11, 1, 0, 1};
        vecs[18] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 11, 1, 0, 1};
        vecs[19] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0,  7, 0, 0, 1};
        vecs[20] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0,  8, 1, 1, 1};
        vecs[21] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,  8, 1, 0, 1};
        vecs[22] = '{1'b1, 1'b1, 8'h40, 1'b0, 1'b0, 1'b0,  8, 2, 0, 1};
        vecs[23] = '{1'b1, 1'b1, 8'hC0, 1'b0, 1'b0, 1'b0,  8, 3, 0, 1};
        vecs[24] = '{1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0,  8, 4, 0, 0};
        vecs[25] = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0,  8, 4, 0, 0};
        vecs[26] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0,  8, 3, 0, 1};
        vecs[27] = '{1'b1, 1'b1, 8'h20, 1'b1, 1'b0, 1'b0,  9, 3, 0, 1};
        vecs[28] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,  8, 0, 0, 1};

        // Reset values after holding reset for three cycles.
        ena = 1'b0; s_valid = 1'b0; s_data = '0; period_tick = 1'b0; vol_up = 1'b0; vol_dn = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_duty",     int'(duty),     MID);
        checkOutput("reset_level",    int'(level),    0);
        checkOutput("reset_ready",    int'(s_ready),  1);
        checkOutput("reset_underrun", int'(underrun), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        $display("[TB] directed vector table");
        for (int i = 0; i < 29; i++) begin
            applyStimulus(vecs[i].ena, vecs[i].valid, vecs[i].data, vecs[i].tick, vecs[i].up, vecs[i].dn);
`ifdef PWM_DUTY_FEEDER_DITHER_EN
            exp_duty = m_duty;
`else
            exp_duty = vecs[i].duty;
`endif
            checkOutput($sformatf("vec%0d_duty", i),     int'(duty),     exp_duty);
            checkOutput($sformatf("vec%0d_level", i),    int'(level),    vecs[i].level);
            checkOutput($sformatf("vec%0d_underrun", i), int'(underrun), vecs[i].under);
            checkOutput($sformatf("vec%0d_ready", i),    int'(s_ready),  vecs[i].ready);
        end

        $display("[TB] randomized run against reference model");
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) begin
                ena = 1'b0; s_valid = 1'b0; period_tick = 1'b0; vol_up = 1'b0; vol_dn = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                checkOutput("async_reset_duty",     int'(duty),     MID);
                checkOutput("async_reset_level",    int'(level),    0);
                checkOutput("async_reset_ready",    int'(s_ready),  1);
                checkOutput("async_reset_underrun", int'(underrun), 0);
                @(negedge clk);
                rst_n = 1'b1;
                model_reset();
            end
            applyStimulus($urandom_range(0, 15) != 0, $urandom_range(0, 1) == 1, 8'($urandom),
                          $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            checkAgainstModel("rand");
        end

        $display("[TB] pop run of zero samples at full volume");
        resetDut();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        n8_dut = 0; n9_dut = 0; n8_ref = 0; n9_ref = 0;
        m_pops = 0;
        cyc = 0;
        while (m_pops < 256 && cyc < 600) begin
            applyStimulus(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
            cyc++;
            if (m_popped) begin
                checkOutput("dither_duty", int'(duty), m_duty);
                checkOutput("dither_range", (duty == 4'd8 || duty == 4'd9) ? 1 : 0, 1);
                if (duty == 4'd9) n9_dut++;
                if (duty == 4'd8) n8_dut++;
                if (m_duty == 9) n9_ref++;
                if (m_duty == 8) n8_ref++;
            end
        end
        checkOutput("dither_pop_count", m_pops, 256);
        checkOutput("dither_n9", n9_dut, n9_ref);
        checkOutput("dither_n8", n8_dut, n8_ref);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
